// File: rtl/camera_dvp_tx.sv
// OV7670-style DVP transmitter: serialises an RGB565 valid/ready pixel stream into
// vsync/href/p_data byte timing with fixed line and frame geometry.
module camera_dvp_tx #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          H_BLANK     = 288,
    parameter int          VSYNC_LINES = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter logic [15:0] FILL_COLOR  = 16'hF800
) (
    input  logic        p_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] in_pixel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic        underrun
);

    localparam int LINE      = 2 * H_ACTIVE + H_BLANK;
    localparam int MAX_VB    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_VF    = (MAX_VB > V_FRONT) ? MAX_VB : V_FRONT;
    localparam int MAX_LINES = (MAX_VF > V_ACTIVE) ? MAX_VF : V_ACTIVE;
    localparam int BYTE_W    = $clog2(LINE);
    localparam int LINE_W    = $clog2(MAX_LINES + 1);

    localparam logic [BYTE_W-1:0] LINE_LAST = BYTE_W'(LINE - 1);
    localparam logic [BYTE_W-1:0] ACT_LAST  = BYTE_W'(2 * H_ACTIVE - 1);
    localparam logic [BYTE_W-1:0] HBL_LAST  = BYTE_W'(H_BLANK - 1);
    localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] VF_LAST   = LINE_W'(V_FRONT - 1);
    localparam logic [LINE_W-1:0] ROW_LAST  = LINE_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   byteCnt_q, byteCnt_d;
    logic [LINE_W-1:0]   lineCnt_q, lineCnt_d;
    logic [LINE_W-1:0]   rowCnt_q, rowCnt_d;
    logic [15:0]         pixel_q, pixel_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          pData_q, pData_d;
    logic                frameStart_q, frameStart_d;
    logic                underrun_q, underrun_d;
    logic                lineTimed;
    logic                lineEnd;
    logic [15:0]         captured;

    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byteCnt_q    <= '0;
            lineCnt_q    <= '0;
            rowCnt_q     <= '0;
            pixel_q      <= '0;
            vsync_q      <= 1'b1;
            href_q       <= 1'b0;
            pData_q      <= '0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byteCnt_q    <= byteCnt_d;
            lineCnt_q    <= lineCnt_d;
            rowCnt_q     <= rowCnt_d;
            pixel_q      <= pixel_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            pData_q      <= pData_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
        end
    end

    // Vertical states are measured in whole line periods; active/blank states count bytes only.
    assign lineTimed = (state_q == VSYNC) || (state_q == VBACK) || (state_q == VFRONT);
    assign lineEnd   = (byteCnt_q == LINE_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (enable) state_d = VSYNC;
            VSYNC:  if (lineEnd && lineCnt_q == VS_LAST) state_d = VBACK;
            VBACK:  if (lineEnd && lineCnt_q == VB_LAST) state_d = ACTIVE;
            ACTIVE: if (byteCnt_q == ACT_LAST) state_d = HBLANK;
            HBLANK: begin
                if (byteCnt_q == HBL_LAST) begin
                    state_d = (rowCnt_q == ROW_LAST) ? VFRONT : ACTIVE;
                end
            end
            VFRONT: begin
                if (lineEnd && lineCnt_q == VF_LAST) begin
                    state_d = enable ? VSYNC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byteCnt_d = byteCnt_q;
        lineCnt_d = lineCnt_q;
        rowCnt_d  = rowCnt_q;
        if (state_d != state_q) begin
            byteCnt_d = '0;
            lineCnt_d = '0;
        end else if (state_q != IDLE) begin
            if (lineTimed && lineEnd) begin
                byteCnt_d = '0;
                lineCnt_d = lineCnt_q + 1'b1;
            end else begin
                byteCnt_d = byteCnt_q + 1'b1;
            end
        end
        if (state_q == VBACK && state_d == ACTIVE) begin
            rowCnt_d = '0;
        end else if (state_q == HBLANK && state_d == ACTIVE) begin
            rowCnt_d = rowCnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the upcoming state so the registered pins line up with state_q;
    // the pixel slot opens the cycle before every high byte and never waits for the source.
    assign captured = in_valid ? in_pixel : FILL_COLOR;

    always_comb begin
        vsync_d      = (state_d == IDLE) || (state_d == VSYNC);
        href_d       = (state_d == ACTIVE);
        frameStart_d = (state_d == VBACK) && (state_q != VBACK);
        in_ready     = href_d && !byteCnt_d[0];
        pixel_d      = in_ready ? captured : pixel_q;
        underrun_d   = underrun_q || (in_ready && !in_valid);
        pData_d      = 8'h00;
        if (href_d) begin
            pData_d = byteCnt_d[0] ? pixel_q[7:0] : captured[15:8];
        end
    end

    assign vsync       = vsync_q;
    assign href        = href_q;
    assign p_data      = pData_q;
    assign frame_start = frameStart_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_camera_dvp_tx.sv
// Bench for camera_dvp_tx: frame-position reference model checked every cycle, a loopback
// byte capture scoreboard, and hand-computed timing/data expectations for a 4x3 frame.
module tb_camera_dvp_tx;

    localparam int H     = 4;
    localparam int VA    = 3;
    localparam int HB    = 2;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LINE  = 2 * H + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LINE;
    localparam int PIX   = H * VA;
    localparam logic [15:0] FILL = 16'hF800;

    logic        p_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  p_data;
    logic        frame_start;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    always #5 p_clock = ~p_clock;

    camera_dvp_tx #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .FILL_COLOR(FILL)
    ) dut (
        .p_clock(p_clock), .reset(reset), .enable(enable),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .vsync(vsync), .href(href), .p_data(p_data),
        .frame_start(frame_start), .underrun(underrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame timeline, derived purely from line geometry.
    bit          mRun    = 1'b0;
    int          mPos    = 0;
    logic [15:0] mPix    = '0;
    bit          mUnder  = 1'b0;
    int          mFrames = 0;
    logic [15:0] acc[$];

    function automatic bit hrefAt(input int p);
        int a;
        a = p - (VS + VB) * LINE;
        return (a >= 0) && (a < VA * LINE) && ((a % LINE) < 2 * H);
    endfunction

    function automatic bit highAt(input int p);
        int a;
        a = p - (VS + VB) * LINE;
        return hrefAt(p) && (((a % LINE) % 2) == 0);
    endfunction

    function automatic bit expReady();
        return mRun && (mPos + 1 < FRAME) && highAt(mPos + 1);
    endfunction

    always @(posedge p_clock or posedge reset) begin
        if (reset) begin
            mRun   <= 1'b0;
            mPos   <= 0;
            mPix   <= '0;
            mUnder <= 1'b0;
            acc.delete();
        end else begin
            if (expReady()) begin
                mPix <= in_valid ? in_pixel : FILL;
                if (!in_valid) mUnder <= 1'b1;
                acc.push_back(in_valid ? in_pixel : FILL);
            end
            if (!mRun) begin
                if (enable) begin
                    mRun <= 1'b1;
                    mPos <= 0;
                end
            end else if (mPos == FRAME - 1) begin
                mFrames <= mFrames + 1;
                mPos    <= 0;
                if (!enable) mRun <= 1'b0;
            end else begin
                mPos <= mPos + 1;
            end
        end
    end

    always @(negedge p_clock) begin
        logic [7:0] expData;
        expData = 8'h00;
        if (mRun && hrefAt(mPos)) expData = highAt(mPos) ? mPix[15:8] : mPix[7:0];
        checkOutput("vsync", vsync, (!mRun || mPos < VS * LINE));
        checkOutput("href", href, (mRun && hrefAt(mPos)));
        checkOutput("p_data", p_data, expData);
        checkOutput("frame_start", frame_start, (mRun && mPos == VS * LINE));
        checkOutput("in_ready", in_ready, expReady());
        checkOutput("underrun", underrun, mUnder);
    end

    // Loopback capture: rebuilds pixels from the byte stream and counts frames on vsync rise.
    bit          phase = 1'b0;
    bit          prevV = 1'b1;
    logic [7:0]  hiB;
    int          capCount   = 0;
    int          loopFrames = 0;

    always @(negedge p_clock) begin
        logic [15:0] exp;
        if (reset) begin
            phase    = 1'b0;
            capCount = 0;
            prevV    = 1'b1;
        end else begin
            if (href) begin
                if (!phase) begin
                    hiB   = p_data;
                    phase = 1'b1;
                end else begin
                    phase = 1'b0;
                    capCount++;
                    if (acc.size() == 0) begin
                        checkOutput("loopback queue", 0, 1);
                    end else begin
                        exp = acc.pop_front();
                        checkOutput("loopback pixel", {hiB, p_data}, exp);
                    end
                end
            end
            if (vsync && !prevV) begin
                checkOutput("pixels per frame", capCount, PIX);
                loopFrames++;
                capCount = 0;
            end
            prevV = vsync;
        end
    end

    int srcMode = 0;
    int srcIdx  = 0;
    int slotIdx = 0;

    task automatic applyStimulus();
        bit took;
        bit slot;
        took = in_ready && in_valid;
        slot = in_ready;
        @(posedge p_clock);
        #1;
        if (slot) slotIdx++;
        if (frame_start) slotIdx = 0;
        if (took) srcIdx++;
        case (srcMode)
            0: begin
                in_valid = 1'b1;
                in_pixel = {8'(2 * srcIdx + 1), 8'(2 * srcIdx + 2)};
            end
            1: begin
                in_valid = !(in_ready && slotIdx == 4);
                in_pixel = {8'(2 * srcIdx + 1), 8'(2 * srcIdx + 2)};
            end
            default: begin
                if (took) in_pixel = 16'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
            end
        endcase
    endtask

    int         vsFall, vsRise, fsAt, fsCount, hrefFirst, hrefCnt, taken, nb, waited;
    logic [7:0] bytes[24];

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge p_clock);
        #1;
        checkOutput("reset vsync", vsync, 1);
        checkOutput("reset href", href, 0);
        checkOutput("reset p_data", p_data, 0);
        checkOutput("reset in_ready", in_ready, 0);
        reset = 1'b0;

        repeat (50) applyStimulus();
        checkOutput("idle vsync", vsync, 1);
        checkOutput("idle href", href, 0);

        // First frame with an always-valid counting source.
        enable = 1'b1;
        vsFall = -1; vsRise = -1; fsAt = -1; fsCount = 0;
        hrefFirst = -1; hrefCnt = 0; taken = 0; nb = 0;
        for (int i = 1; i <= 61; i++) begin
            applyStimulus();
            if (!vsync && vsFall < 0) vsFall = i;
            if (vsync && vsFall > 0 && vsRise < 0) vsRise = i;
            if (frame_start) begin fsCount++; fsAt = i; end
            if (href) begin
                if (hrefFirst < 0) hrefFirst = i;
                hrefCnt++;
                if (nb < 4) begin bytes[nb] = p_data; nb++; end
            end
            if (in_ready && in_valid) taken++;
        end
        checkOutput("vsync fall cycle", vsFall, 11);
        checkOutput("frame_start cycle", fsAt, 11);
        checkOutput("frame_start count", fsCount, 1);
        checkOutput("href first cycle", hrefFirst, 21);
        checkOutput("href high cycles", hrefCnt, 24);
        checkOutput("byte0", bytes[0], 8'h01);
        checkOutput("byte1", bytes[1], 8'h02);
        checkOutput("byte2", bytes[2], 8'h03);
        checkOutput("byte3", bytes[3], 8'h04);
        checkOutput("pixels taken", taken, 12);
        checkOutput("vsync rise cycle", vsRise, 61);

        // Second frame: fifth pixel slot finds the source not valid.
        checkOutput("underrun before drop", underrun, 0);
        srcMode = 1;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            if (href && nb < 24) begin bytes[nb] = p_data; nb++; end
        end
        checkOutput("frame2 byte count", nb, 24);
        checkOutput("pixel4 high", bytes[6], 8'h1F);
        checkOutput("pixel4 low", bytes[7], 8'h20);
        checkOutput("fill high", bytes[8], 8'hF8);
        checkOutput("fill low", bytes[9], 8'h00);
        checkOutput("pixel6 high", bytes[10], 8'h21);
        checkOutput("pixel6 low", bytes[11], 8'h22);
        checkOutput("underrun sticky", underrun, 1);

        // Third frame: enable dropped during line 2, frame still completes.
        srcMode = 0;
        repeat (35) applyStimulus();
        enable  = 1'b0;
        hrefCnt = 0;
        repeat (25) begin
            applyStimulus();
            if (href) hrefCnt++;
        end
        checkOutput("href after enable drop", hrefCnt, 10);
        checkOutput("idle after drop vsync", vsync, 1);
        fsCount = 0;
        repeat (20) begin
            applyStimulus();
            if (frame_start) fsCount++;
        end
        checkOutput("no frame while idle", fsCount, 0);

        // Random source, then reset in the middle of an active line.
        srcMode = 2;
        enable  = 1'b1;
        waited  = 0;
        while (!href && waited < 200) begin
            applyStimulus();
            waited++;
        end
        checkOutput("href reached", href, 1);
        repeat (2) applyStimulus();
        reset = 1'b1;
        #1;
        checkOutput("midline reset vsync", vsync, 1);
        checkOutput("midline reset href", href, 0);
        checkOutput("midline reset p_data", p_data, 0);
        checkOutput("midline reset underrun", underrun, 0);
        checkOutput("midline reset in_ready", in_ready, 0);
        repeat (2) applyStimulus();
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            enable = ($urandom_range(0, 9) != 0);
        end
        enable = 1'b0;
        repeat (130) applyStimulus();
        checkOutput("loopback frames", loopFrames, mFrames);
        checkOutput("final vsync", vsync, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
